// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and helpers for the data-memory responder
package dmem_pkg;
  localparam logic [1:0] OFF_CYCLE  = 2'd0;
  localparam logic [1:0] OFF_TXDATA = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: CPU data port plus console byte stream
interface dmem_responder_if;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  modport master (output daddr, dwdata, dwe, tx_ready, input drdata, tx_data, tx_valid);
  modport slave  (input daddr, dwdata, dwe, tx_ready, output drdata, tx_data, tx_valid);
endinterface

// File: rtl/dmem_responder_sync_fifo.sv
// sync_fifo: power-of-two FIFO; a push into a full FIFO succeeds when a pop frees a slot that cycle
module sync_fifo
  import dmem_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = log2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             dropped,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic pop_ok, push_ok;
  always_comb begin
    empty   = count == '0;
    full    = count == CW'(DEPTH);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    dropped = push && !push_ok;
    dout    = empty ? '0 : mem[rd];
  end
  always_ff @(posedge clk)
    if (reset) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wr <= wr + AW'(1);
      if (pop_ok) rd <= rd + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  always_ff @(posedge clk)
    if (!reset && push_ok) mem[wr] <= din;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM with byte-lane writes plus cycle counter, console FIFO and status MMIO
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int IW = log2(MEM_WORDS);
  localparam int CW = log2(FIFO_DEPTH) + 1;
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] cycle;
  logic [31:0] status;
  logic [IW-1:0] idx;
  logic [1:0] off;
  logic [CW-1:0] count;
  logic in_ram, in_mmio, push, clr, ovf, full, empty, dropped;
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.daddr[1:0]};
  always_comb begin
    idx     = bus.daddr[IW+1:2];
    off     = bus.daddr[3:2];
    in_ram  = (bus.daddr >> (IW + 2)) == 32'd0;
    in_mmio = bus.daddr[31:4] == MMIO_BASE[31:4];
    push    = !reset && in_mmio && off == OFF_TXDATA && bus.dwe[0];
    clr     = in_mmio && off == OFF_STATUS && bus.dwe[0] && bus.dwdata[2];
    status  = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL]  = full;
    status[ST_OVF]   = ovf;
    status[ST_COUNT_LSB +: 8] = 8'(count);
    bus.drdata = in_ram ? mem[idx] :
                 in_mmio && off == OFF_CYCLE  ? cycle :
                 in_mmio && off == OFF_STATUS ? status : '0;
    bus.tx_valid = !empty;
  end
  always_ff @(posedge clk)
    if (!reset && in_ram)
      for (int n = 0; n < 4; n++)
        if (bus.dwe[n]) mem[idx][8*n +: 8] <= bus.dwdata[8*n +: 8];
  always_ff @(posedge clk)
    cycle <= reset ? '0 : cycle + 32'd1;
  // a drop outranks a same-cycle clear so no overflow event is lost
  always_ff @(posedge clk)
    if (reset) ovf <= 1'b0;
    else if (dropped) ovf <= 1'b1;
    else if (clr) ovf <= 1'b0;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(bus.tx_ready),
    .din(bus.dwdata[7:0]),
    .dout(bus.tx_data),
    .full(full),
    .empty(empty),
    .dropped(dropped),
    .count(count)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table vectors, directed corners and random traffic against a queue-based model
module tb_dmem_responder;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'h8000_0000;
  logic clk = 0, reset = 1;
  dmem_responder_if bus();
  dmem_responder #(.MEM_WORDS(1024), .FIFO_DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    string nm;
    logic r;
    logic [31:0] a, wd;
    logic [3:0] we;
    logic rdy, crd;
    logic [31:0] erd;
    logic ev;
    logic [7:0] ed;
  } vec_t;
  vec_t tbl[$];
  int n_vec = 0, n_bad = 0;
  logic [7:0] rb [int];
  logic [7:0] q[$];
  logic [31:0] m_cyc = 0;
  bit m_ovf = 0, m_ok = 0;
  logic [31:0] rd;
  logic v;
  logic [7:0] d;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic bit m_read(input logic [31:0] a, output logic [31:0] e);
    e = 0;
    if (a < 32'd4096) begin
      for (int n = 0; n < 4; n++) begin
        int k;
        k = int'(a & ~32'h3) + n;
        if (!rb.exists(k)) return 0;
        e[8*n +: 8] = rb[k];
      end
      return 1;
    end
    if (a[31:4] == BASE[31:4])
      case (a[3:2])
        2'd0: e = m_cyc;
        2'd2: e = {16'd0, 8'(q.size()), 5'd0, m_ovf, q.size() == DEPTH, q.size() == 0};
        default: e = 0;
      endcase
    return 1;
  endfunction
  task automatic m_step(input logic r, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we, input logic rdy);
    bit pop, push, clr, was_full;
    if (r) begin
      m_cyc = 0;
      q.delete();
      m_ovf = 0;
      m_ok = 1;
      return;
    end
    if (a < 32'd4096)
      for (int n = 0; n < 4; n++)
        if (we[n]) rb[int'(a & ~32'h3) + n] = wd[8*n +: 8];
    push = a[31:4] == BASE[31:4] && a[3:2] == 2'd1 && we[0];
    clr = a[31:4] == BASE[31:4] && a[3:2] == 2'd2 && we[0] && wd[2];
    pop = q.size() != 0 && rdy;
    was_full = q.size() == DEPTH;
    if (clr) m_ovf = 0;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (!was_full || pop) q.push_back(wd[7:0]);
      else m_ovf = 1;
    end
    m_cyc++;
  endtask
  task automatic apply(input logic r, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we, input logic rdy);
    logic [31:0] e;
    reset = r;
    bus.daddr = a;
    bus.dwdata = wd;
    bus.dwe = we;
    bus.tx_ready = rdy;
    #1;
    rd = bus.drdata;
    v = bus.tx_valid;
    d = bus.tx_data;
    if (m_ok) begin
      if (m_read(a, e)) chk("model drdata", rd, e);
      chk("model tx_valid", 32'(v), 32'(q.size() != 0));
      chk("model tx_data", 32'(d), q.size() != 0 ? 32'(q[0]) : 32'd0);
    end
    @(posedge clk);
    m_step(r, a, wd, we, rdy);
    #1;
  endtask
  function automatic void add(input string nm, input logic r, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] we, input logic rdy, input logic crd, input logic [31:0] erd,
                              input logic ev, input logic [7:0] ed);
    vec_t x;
    x.nm = nm; x.r = r; x.a = a; x.wd = wd; x.we = we; x.rdy = rdy;
    x.crd = crd; x.erd = erd; x.ev = ev; x.ed = ed;
    tbl.push_back(x);
  endfunction
  initial begin
    logic [31:0] a, wd;
    logic [3:0] we;
    logic rdy, r;
    int bias;
    add("sw first", 0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
    add("sw old word", 0, 32'h10, 32'h11223344, 4'hF, 0, 1, 32'hDEADBEEF, 0, 0);
    add("sb old word", 0, 32'h10, 32'h0000AA00, 4'h2, 0, 1, 32'h11223344, 0, 0);
    add("lane merge", 0, 32'h10, 0, 4'h0, 0, 1, 32'h1122AA44, 0, 0);
    add("sw top word", 0, 32'hFFC, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, 0);
    add("top word", 0, 32'hFFC, 0, 4'h0, 0, 1, 32'hCAFEF00D, 0, 0);
    add("no alias", 0, 32'h1010, 0, 4'h0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add("fill", 0, BASE + 4, 32'h41 + i, 4'h1, 0, 1, 0, i != 0, i != 0 ? 8'h41 : 8'h00);
    add("push full", 0, BASE + 4, 32'h49, 4'h1, 0, 1, 0, 1, 8'h41);
    add("status ovf", 0, BASE + 8, 0, 4'h0, 0, 1, 32'h0806, 1, 8'h41);
    add("clear ovf", 0, BASE + 8, 32'h4, 4'h1, 0, 1, 32'h0806, 1, 8'h41);
    add("status clr", 0, BASE + 8, 0, 4'h0, 0, 1, 32'h0802, 1, 8'h41);
    for (int k = 0; k < 8; k++)
      add("drain", 0, BASE + 8, 0, 4'h0, 1, 1, k == 0 ? 32'h0802 : {16'd0, 8'(8 - k), 8'd0}, 1, 8'(8'h41 + k));
    add("drained", 0, BASE + 8, 0, 4'h0, 1, 1, 32'h0001, 0, 0);
    for (int i = 0; i < 8; i++)
      add("refill", 0, BASE + 4, 32'h50 + i, 4'h1, 0, 1, 0, i != 0, i != 0 ? 8'h50 : 8'h00);
    add("push pop full", 0, BASE + 4, 32'h5A, 4'h1, 1, 1, 0, 1, 8'h50);
    add("still full", 0, BASE + 8, 0, 4'h0, 0, 1, 32'h0802, 1, 8'h51);
    for (int k = 0; k < 8; k++)
      add("drain2", 0, BASE + 8, 0, 4'h0, 1, 1, k == 0 ? 32'h0802 : {16'd0, 8'(8 - k), 8'd0}, 1,
          k == 7 ? 8'h5A : 8'(8'h51 + k));
    add("drained2", 0, BASE + 8, 0, 4'h0, 0, 1, 32'h0001, 0, 0);
    add("sw unmapped", 0, 32'h4000_0000, 32'hFFFFFFFF, 4'hF, 0, 1, 0, 0, 0);
    add("sw reserved", 0, BASE + 12, 32'hFFFFFFFF, 4'hF, 0, 1, 0, 0, 0);
    add("txdata reads 0", 0, BASE + 4, 0, 4'h0, 0, 1, 0, 0, 0);
    add("ram intact", 0, 32'h10, 0, 4'h0, 0, 1, 32'h1122AA44, 0, 0);
    add("status intact", 0, BASE + 8, 0, 4'h0, 0, 1, 32'h0001, 0, 0);
    for (int i = 0; i < 3; i++)
      add("queue3", 0, BASE + 4, 32'h61 + i, 4'h1, 0, 1, 0, i != 0, i != 0 ? 8'h61 : 8'h00);
    add("reset mid", 1, 32'h2000, 0, 4'h0, 0, 1, 0, 1, 8'h61);
    add("after reset", 0, BASE + 8, 0, 4'h0, 0, 1, 32'h0001, 0, 0);
    apply(1, 32'h2000, 0, 0, 0);
    apply(1, 32'h2000, 0, 0, 0);
    apply(0, BASE + 8, 0, 0, 0);
    chk("reset status", rd, 32'h0001);
    chk("reset tx_valid", 32'(v), 0);
    chk("reset tx_data", 32'(d), 0);
    apply(0, BASE, 0, 0, 0);
    apply(0, BASE, 32'hFFFF, 4'hF, 0);
    apply(0, BASE, 0, 0, 0);
    apply(0, BASE, 0, 0, 0);
    chk("cycle 5th", rd, 32'd4);
    bus.daddr = BASE;
    bus.dwe = 0;
    force dut.cycle = 32'hFFFF_FFFF;
    #1;
    chk("cycle forced", bus.drdata, 32'hFFFF_FFFF);
    release dut.cycle;
    @(posedge clk);
    m_cyc = 32'hFFFF_FFFF;
    m_step(0, BASE, 0, 0, 0);
    #1;
    chk("cycle wrap", bus.drdata, 32'd0);
    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].a, tbl[i].wd, tbl[i].we, tbl[i].rdy);
      if (tbl[i].crd) chk(tbl[i].nm, rd, tbl[i].erd);
      chk({tbl[i].nm, " valid"}, 32'(v), 32'(tbl[i].ev));
      chk({tbl[i].nm, " data"}, 32'(d), 32'(tbl[i].ed));
    end
    for (int i = 0; i < 800; i++) begin
      bias = (i / 100) % 3;
      rdy = $urandom_range(0, 3) < bias + 1;
      r = $urandom_range(0, 99) == 0;
      wd = $urandom;
      we = 0;
      case ($urandom_range(0, 9))
        0, 1: begin
          a = $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) << 2 : 32'($urandom_range(1008, 1023)) << 2;
          we = 4'($urandom_range(1, 15));
        end
        2, 3: a = $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) << 2 : 32'($urandom_range(1008, 1023)) << 2;
        4, 5: begin a = BASE + 4; we = 4'($urandom_range(0, 15)); end
        6: begin a = BASE + 8; we = 4'($urandom_range(0, 3)); end
        7: begin a = BASE; we = 4'($urandom_range(0, 15)); end
        8: begin a = $urandom | 32'h0000_1000; we = 4'($urandom_range(0, 15)); end
        default: a = BASE + 8;
      endcase
      a = a | 32'($urandom_range(0, 3));
      apply(r, a, wd, we, rdy);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the single-cycle CPU's data port. It answers daddr/dwdata/dwe with same-cycle combinational read data on drdata, and performs byte-lane writes on the clock edge. It also decodes a small MMIO window containing a free-running cycle counter, a console transmit FIFO drained over a valid/ready byte stream, and a status register. It sits beside the CPU in the top level, in place of a bare RAM model.

Parameters:
MEM_WORDS, 1024, number of 32-bit RAM words; power of two.
FIFO_DEPTH, 8, console TX FIFO entries; power of two, 2..128.
MMIO_BASE, 32'h8000_0000, base address of the MMIO window; aligned to 16 bytes.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
daddr  input  32  byte address from the CPU; bits [1:0] are ignored (word access).
dwdata  input  32  write data; lanes are taken unshifted, as presented.
dwe  input  4  per-byte write enable; bit n writes dwdata[8n+7:8n]; 0 means read.
drdata  output  32  combinational read data for daddr.
tx_data  output  8  byte at the head of the console FIFO.
tx_valid  output  1  FIFO non-empty.
tx_ready  input  1  consumer accepts the head byte this cycle.

Behaviour:
- Reset (reset high at a posedge): cycle counter = 0, FIFO empty, overflow flag = 0, tx_valid = 0, tx_data = 0. RAM contents are not cleared. Writes are ignored in any cycle where reset is high.
- RAM region: daddr < MEM_WORDS*4; index is daddr[log2(MEM_WORDS)+1:2].
  - Read: drdata = mem[index], zero latency.
  - Write: at the posedge, each lane with dwe[n]=1 is updated.
  - Read-during-write: drdata shows the old word during the write cycle; the new word is visible from the next cycle.
- MMIO window (daddr[31:4] == MMIO_BASE[31:4]), by offset daddr[3:2]:
  - 0 CYCLE (RO): returns the counter value before this edge's increment. Counter increments every non-reset cycle and wraps 32'hFFFF_FFFF -> 0. Writes are ignored.
  - 1 TXDATA (WO): a write with dwe[0]=1 pushes dwdata[7:0]. Reads return 0.
  - 2 STATUS: bit0 = empty, bit1 = full, bit2 = overflow (sticky), bits[15:8] = entry count (zero-extended), all other bits 0. A write with dwe[0]=1 and dwdata[2]=1 clears overflow.
  - 3 reserved: reads return 0, writes are ignored.
- Any other address: drdata = 0, writes ignored, no side effects.
- FIFO rules:
  - Pop when tx_valid && tx_ready. The read pointer advances and tx_data shows the next entry in the following cycle.
  - Push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle (full with simultaneous push and pop keeps count unchanged).
  - Otherwise the push is dropped and overflow is set.
  - Simultaneous push and pop when empty: the push is stored, no pop occurs, and tx_valid rises next cycle.
  - Pointers wrap modulo FIFO_DEPTH; count has width log2(FIFO_DEPTH)+1.
  - tx_valid = (count != 0). tx_data = head entry, or 0 when empty.
  - tx_data must remain stable while tx_valid && !tx_ready.
- STATUS overflow set and clear in the same cycle: set wins.
- Reset mid-stream: the FIFO empties immediately at that edge and any in-flight byte is discarded. tx_valid is low the next cycle.
- dwe is non-zero only for stores. Loads rely solely on combinational drdata.

Decomposition:
- Package dmem_pkg:
  - MMIO offset constants OFF_CYCLE=0, OFF_TXDATA=1, OFF_STATUS=2.
  - STATUS bit indices ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_COUNT_LSB=8.
  - A function computing log2.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count, same-cycle push-on-full-with-pop). Instantiated once with width 8.

Test Plan:
1. After reset: SW 0x11223344 to 0x10, then dwe=4'b0010 with dwdata=0x0000AA00 to 0x10 -> read 0x10 returns 0x1122AA44. During the first write cycle, drdata still shows the old word.
2. Counter: hold reset 2 cycles, release, read CYCLE on the 5th non-reset cycle -> 4. Force the counter to 0xFFFFFFFF and clock once -> reads 0.
3. FIFO fill: tx_ready=0, push 0x41..0x48 (8 bytes), then push 0x49 -> STATUS = 0x0000_0806 (count 8, full, overflow). Write STATUS with dwdata=4 -> 0x0000_0802.
4. Drain: tx_ready=1 from the state of test 3 -> tx_data sequence 0x41..0x48 on 8 consecutive cycles, then tx_valid=0 and STATUS=0x0000_0001.
5. Full with simultaneous push and pop: FIFO full, tx_ready=1 and push 0x5A in the same cycle -> count stays 8, overflow stays 0, 0x5A emerges last.
6. Unmapped and reserved: SW to 0x4000_0000 and to MMIO_BASE+0xC -> RAM and STATUS unchanged, reads return 0. Reset asserted with 3 bytes queued -> tx_valid=0 next cycle, STATUS=0x0000_0001.
